tcdm_bus_convert_32_to_36: RTL and testbench
============================================

# tcdm_bus_convert_32_to_36

Converts a 32-bit TCDM master port into a 36-bit tagged (DIFT) TCDM slave access, so untagged initiators can reach tag-extended memory. Each write is extended with per-byte tag bits. Each read response is checked against those tags through a registered pending-read tracker, and the result feeds sticky violation-reporting registers. The block sits between a 32-bit initiator and the 36-bit interconnect or memory port.

## Interface
Parameters:
- TAG_WRITE_VALUE, 1'b1: tag bit written for every byte of a 32-bit write; also the "clean" tag value expected on reads.
- MASK_TAINTED, 1'b0: when 1, read bytes whose tag differs from TAG_WRITE_VALUE are returned as 8'h00.
- CNT_WIDTH, 16: width of the violation counter.

Ports (clock and reset first):
- clk_i, input, 1: clock.
- rst_i, input, 1: synchronous, active-high reset.
- slave_32, XBAR_TCDM_BUS.Slave, –: 32-bit side (req, add[31:0], wen, be[3:0], wdata[31:0], gnt, r_rdata[31:0], r_opc, r_valid).
- master_36, XBAR_TCDM_BUS_36.Master, –: tagged side (same signals; wdata/r_rdata are [35:0], bits 35:32 = tags for bytes 3..0).
- tag_viol_clr_i, input, 1: clears the sticky flag, captured address and counter.
- tag_viol_o, output, 1: single-cycle pulse on a read with a tag mismatch.
- tag_viol_sticky_o, output, 1: set on the first violation, held until clear.
- tag_viol_addr_o, output, 32: address of the first violation since the last clear/reset.
- tag_viol_cnt_o, output, CNT_WIDTH: saturating count of violating reads.

## Operation
- Request path is combinational pass-through: req, add, wen, be, gnt.
- master_36.wdata = {4{TAG_WRITE_VALUE}, slave_32.wdata}.
- Tags are written for all four bytes regardless of be; memory honours be per 9-bit lane.
- Pending tracker: on req & gnt & wen (read), load pend_vld=1, pend_add=add, pend_be=be.
  - Otherwise pend_vld=0.
  - Reloads every granted cycle, so back-to-back reads are supported.
- Response path: r_valid and r_opc pass through.
- slave_32.r_rdata = master_36.r_rdata[31:0], with mismatching bytes zeroed when MASK_TAINTED=1 and the check is enabled.
- Mismatch vector: mm[i] = pend_be[i] & (r_rdata[32+i] != TAG_WRITE_VALUE).
- A violation is r_valid & pend_vld & |mm. Bytes with be=0 never cause a violation.
- On violation:
  - tag_viol_o=1 for that cycle.
  - Counter increments, saturating at all-ones.
  - If sticky=0: sticky←1 and tag_viol_addr_o←pend_add.
- r_valid with pend_vld=0 (write response or stray) is never checked.
- Clear and violation in the same cycle: the clear applies first, then the violation. Result: sticky=1, addr=pend_add, cnt=1.

## Timing
- Request: 0 cycles of added latency. Response data: 0 cycles (combinational from master_36.r_rdata).
- r_valid is expected exactly one cycle after gnt (TCDM rule). The check uses the pending state registered at the gnt edge.
- tag_viol_o is combinational in the r_valid cycle. Sticky, addr and cnt update on the following clock edge.
- Reset values: pend_vld=0, pend_add=0, pend_be=0, tag_viol_sticky_o=0, tag_viol_addr_o=0, tag_viol_cnt_o=0. tag_viol_o is 0 while pend_vld=0.
- Reset asserted mid-transaction: pending state is dropped. An r_valid in the first cycle after reset is passed through unchecked and unmasked.

## Configuration
- DIFT_TAG_CHECK_EN defined: the pending tracker, mismatch check, masking and violation registers are all built.
- DIFT_TAG_CHECK_EN undefined:
  - slave_32.r_rdata = master_36.r_rdata[31:0] unmodified and no tracker is built.
  - tag_viol_o, tag_viol_sticky_o, tag_viol_addr_o and tag_viol_cnt_o are tied to 0.
  - tag_viol_clr_i is ignored.
  - The write tag extension is always present.

## Test plan
- Write add=0x100, wdata=0xDEADBEEF, be=4'hF → master_36.wdata=0xFDEADBEEF with TAG_WRITE_VALUE=1. No violation.
- Read with be=4'hF, response r_rdata=0xF12345678 → slave gets 0x12345678. tag_viol_o=0, cnt=0.
- Read add=0x200, be=4'h3, tags=4'b1101 → mismatch on byte 1 → pulse, sticky=1, addr=0x200, cnt=1. With MASK_TAINTED=1, data byte 1 reads 0x00.
- Back-to-back reads at 0x300 (tags ok) then 0x304 (tag 0 on byte 0) → only the second violates. addr=0x304 if sticky was clear; cnt+1.
- Force cnt to all-ones, then one more violation → cnt stays all-ones. Then clear together with a violation → sticky=1, cnt=1.
- Assert rst_i in the gnt cycle of a read, then r_valid with bad tags → no violation; all outputs at reset values.

Source files
------------

// File: rtl/tcdm_bus_convert_32_to_36_if.sv
// TCDM bus interfaces used by the 32-to-36 bit converter.
// XBAR_TCDM_BUS carries plain 32-bit data; XBAR_TCDM_BUS_36 carries
// 32 data bits plus one tag bit per byte in bits [35:32] (byte 3..0).

interface XBAR_TCDM_BUS;
    logic        req;
    logic [31:0] add;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        gnt;
    logic [31:0] r_rdata;
    logic        r_opc;
    logic        r_valid;

    modport Master (
        output req, add, wen, wdata, be,
        input  gnt, r_rdata, r_opc, r_valid
    );

    modport Slave (
        input  req, add, wen, wdata, be,
        output gnt, r_rdata, r_opc, r_valid
    );
endinterface

interface XBAR_TCDM_BUS_36;
    logic        req;
    logic [31:0] add;
    logic        wen;
    logic [35:0] wdata;
    logic [3:0]  be;
    logic        gnt;
    logic [35:0] r_rdata;
    logic        r_opc;
    logic        r_valid;

    modport Master (
        output req, add, wen, wdata, be,
        input  gnt, r_rdata, r_opc, r_valid
    );

    modport Slave (
        input  req, add, wen, wdata, be,
        output gnt, r_rdata, r_opc, r_valid
    );
endinterface

// File: rtl/tcdm_bus_convert_32_to_36.sv
// 32-bit TCDM initiator to 36-bit tagged (DIFT) TCDM target converter.
// Writes are extended with a constant per-byte tag. When the macro
// DIFT_TAG_CHECK_EN is defined, read responses are checked against the
// clean tag using a one-entry pending-read tracker, tainted bytes can be
// masked, and violations are reported through a pulse plus sticky flag,
// first-violation address and saturating counter. Without the macro the
// response path is a plain pass-through and all violation outputs are 0.

module tcdm_bus_convert_32_to_36 #(
    parameter logic        TAG_WRITE_VALUE = 1'b1,
    parameter logic        MASK_TAINTED    = 1'b0,
    parameter int unsigned CNT_WIDTH       = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    XBAR_TCDM_BUS.Slave          slave_32,
    XBAR_TCDM_BUS_36.Master      master_36,
    input  logic                 tag_viol_clr_i,
    output logic                 tag_viol_o,
    output logic                 tag_viol_sticky_o,
    output logic [31:0]          tag_viol_addr_o,
    output logic [CNT_WIDTH-1:0] tag_viol_cnt_o
);

    localparam logic [3:0] CLEAN_TAGS = {4{TAG_WRITE_VALUE}};

    // Request path: zero-latency pass-through, tags appended to write data.
    // Tags go on all four lanes; the memory applies be per 9-bit lane.
    assign master_36.req   = slave_32.req;
    assign master_36.add   = slave_32.add;
    assign master_36.wen   = slave_32.wen;
    assign master_36.be    = slave_32.be;
    assign master_36.wdata = {CLEAN_TAGS, slave_32.wdata};
    assign slave_32.gnt    = master_36.gnt;

    // Response handshake passes straight through.
    assign slave_32.r_valid = master_36.r_valid;
    assign slave_32.r_opc   = master_36.r_opc;

`ifdef DIFT_TAG_CHECK_EN

    // Pending-read tracker: describes the read granted in the previous cycle.
    logic        pend_vld_q, pend_vld_d;
    logic [31:0] pend_add_q, pend_add_d;
    logic [3:0]  pend_be_q,  pend_be_d;

    // Violation reporting state.
    logic                 sticky_q, sticky_d;
    logic [31:0]          viol_addr_q, viol_addr_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // Response check signals.
    logic [3:0]  resp_tags;
    logic [3:0]  mismatch;
    logic        check_active;
    logic        viol;
    logic [31:0] rdata_checked;

    // Capture every granted read; any other cycle invalidates the entry so
    // back-to-back reads simply overwrite it.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        pend_vld_d = slave_32.req & master_36.gnt & slave_32.wen;
        pend_add_d = pend_add_q;
        pend_be_d  = pend_be_q;
        if (pend_vld_d) begin
            pend_add_d = slave_32.add;
            pend_be_d  = slave_32.be;
        end
    end

    // Compare returned tags with the clean value on the enabled bytes only.
    assign resp_tags    = master_36.r_rdata[35:32];
    assign mismatch     = pend_be_q & (resp_tags ^ CLEAN_TAGS);
    assign check_active = master_36.r_valid & pend_vld_q;
    assign viol         = check_active & (|mismatch);

    // Optionally zero tainted bytes of a checked response.
    always_comb begin
        rdata_checked = master_36.r_rdata[31:0];
        for (int i = 0; i < 4; i++) begin
            if (MASK_TAINTED && check_active && mismatch[i]) begin
                rdata_checked[8*i +: 8] = 8'h00;
            end
        end
    end

    // Violation bookkeeping: clear is applied first, then the violation.
    always_comb begin
        logic                 sticky_base;
        logic [31:0]          addr_base;
        logic [CNT_WIDTH-1:0] cnt_base;

        sticky_base = tag_viol_clr_i ? 1'b0 : sticky_q;
        addr_base   = tag_viol_clr_i ? 32'h0 : viol_addr_q;
        cnt_base    = tag_viol_clr_i ? '0 : cnt_q;

        sticky_d    = sticky_base;
        viol_addr_d = addr_base;
        cnt_d       = cnt_base;

        if (viol) begin
            if (cnt_base != {CNT_WIDTH{1'b1}}) begin
                cnt_d = cnt_base + 1'b1;
            end
            if (!sticky_base) begin
                sticky_d    = 1'b1;
                viol_addr_d = pend_add_q;
            end
        end
    end

    // State registers with synchronous reset; reset drops any pending read.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst_i) begin
            pend_vld_q  <= 1'b0;
            pend_add_q  <= 32'h0;
            pend_be_q   <= 4'h0;
            sticky_q    <= 1'b0;
            viol_addr_q <= 32'h0;
            cnt_q       <= '0;
        end else begin
            pend_vld_q  <= pend_vld_d;
            pend_add_q  <= pend_add_d;
            pend_be_q   <= pend_be_d;
            sticky_q    <= sticky_d;
            viol_addr_q <= viol_addr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign slave_32.r_rdata  = rdata_checked;
    assign tag_viol_o        = viol;
    assign tag_viol_sticky_o = sticky_q;
    assign tag_viol_addr_o   = viol_addr_q;
    assign tag_viol_cnt_o    = cnt_q;

`else

    // Check disabled: plain data pass-through, reporting tied off.
    assign slave_32.r_rdata  = master_36.r_rdata[31:0];
    assign tag_viol_o        = 1'b0;
    assign tag_viol_sticky_o = 1'b0;
    assign tag_viol_addr_o   = 32'h0;
    assign tag_viol_cnt_o    = '0;

    // Inputs that only matter when the check is built.
    logic unused_sigs;
    assign unused_sigs = ^{clk_i, rst_i, tag_viol_clr_i,
                           master_36.r_rdata[35:32], MASK_TAINTED};

`endif

endmodule

// File: tb/tb_tcdm_bus_convert_32_to_36.sv
// Directed self-checking bench for tcdm_bus_convert_32_to_36.
// Expected values follow whether DIFT_TAG_CHECK_EN is defined.

module tb_tcdm_bus_convert_32_to_36;

`ifdef DIFT_TAG_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        clr;
    logic        viol;
    logic        sticky;
    logic [31:0] vaddr;
    logic [2:0]  vcnt;

    int n_checks = 0;
    int n_fail   = 0;

    XBAR_TCDM_BUS    s32 ();
    XBAR_TCDM_BUS_36 m36 ();

    tcdm_bus_convert_32_to_36 #(
        .TAG_WRITE_VALUE(1'b1),
        .MASK_TAINTED   (1'b1),
        .CNT_WIDTH      (3)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .slave_32         (s32),
        .master_36        (m36),
        .tag_viol_clr_i   (clr),
        .tag_viol_o       (viol),
        .tag_viol_sticky_o(sticky),
        .tag_viol_addr_o  (vaddr),
        .tag_viol_cnt_o   (vcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        s32.req     = 1'b0;
        s32.add     = 32'h0;
        s32.wen     = 1'b1;
        s32.wdata   = 32'h0;
        s32.be      = 4'h0;
        m36.gnt     = 1'b0;
        m36.r_rdata = 36'h0;
        m36.r_opc   = 1'b0;
        m36.r_valid = 1'b0;
    endtask

    // One granted read followed by its response one cycle later.
    task automatic read_txn(input logic [31:0] a, input logic [3:0] be,
                            input logic [3:0] tags, input logic [31:0] d,
                            input logic clr_in,
                            output logic [31:0] rd, output logic v);
        s32.req = 1'b1; s32.wen = 1'b1; s32.add = a; s32.be = be;
        m36.gnt = 1'b1;
        next_cycle();
        s32.req = 1'b0; m36.gnt = 1'b0;
        m36.r_valid = 1'b1; m36.r_rdata = {tags, d}; clr = clr_in;
        #1;
        rd = s32.r_rdata;
        v  = viol;
        next_cycle();
        m36.r_valid = 1'b0; m36.r_rdata = 36'h0; clr = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        n_checks++; if (viol !== 1'b0) begin n_fail++; $display("FAIL reset_viol: got %b expected 0", viol); end
        n_checks++; if (sticky !== 1'b0) begin n_fail++; $display("FAIL reset_sticky: got %b expected 0", sticky); end
        n_checks++; if (vaddr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", vaddr); end
        n_checks++; if (vcnt !== 3'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", vcnt); end
    endtask

    task automatic test_write();
        s32.req = 1'b1; s32.wen = 1'b0; s32.add = 32'h100;
        s32.wdata = 32'hDEADBEEF; s32.be = 4'hF; m36.gnt = 1'b1;
        #1;
        n_checks++; if (m36.wdata !== 36'hFDEADBEEF) begin n_fail++; $display("FAIL write_wdata: got %h expected FDEADBEEF", m36.wdata); end
        n_checks++; if (m36.add !== 32'h100) begin n_fail++; $display("FAIL write_add: got %h expected 100", m36.add); end
        n_checks++; if ({m36.req, m36.wen, m36.be} !== 6'b10_1111) begin n_fail++; $display("FAIL write_ctrl: got %b expected 101111", {m36.req, m36.wen, m36.be}); end
        n_checks++; if (s32.gnt !== 1'b1) begin n_fail++; $display("FAIL write_gnt: got %b expected 1", s32.gnt); end
        next_cycle();
        // Write response with tags that would be bad on a read: never checked.
        s32.req = 1'b0; s32.wen = 1'b1; m36.gnt = 1'b0;
        m36.r_valid = 1'b1; m36.r_opc = 1'b1; m36.r_rdata = 36'h0CAFEBABE;
        #1;
        n_checks++; if ({s32.r_valid, s32.r_opc} !== 2'b11) begin n_fail++; $display("FAIL write_resp_hs: got %b expected 11", {s32.r_valid, s32.r_opc}); end
        n_checks++; if (s32.r_rdata !== 32'hCAFEBABE) begin n_fail++; $display("FAIL write_resp_data: got %h expected CAFEBABE", s32.r_rdata); end
        n_checks++; if (viol !== 1'b0) begin n_fail++; $display("FAIL write_resp_viol: got %b expected 0", viol); end
        next_cycle();
        idle_bus();
        #1;
        n_checks++; if ({sticky, vcnt} !== 4'b0) begin n_fail++; $display("FAIL write_no_report: got %b expected 0000", {sticky, vcnt}); end
    endtask

    task automatic test_read_clean();
        logic [31:0] rd;
        logic        v;
        read_txn(32'h180, 4'hF, 4'hF, 32'h12345678, 1'b0, rd, v);
        n_checks++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL clean_rdata: got %h expected 12345678", rd); end
        n_checks++; if (v !== 1'b0) begin n_fail++; $display("FAIL clean_viol: got %b expected 0", v); end
        n_checks++; if (vcnt !== 3'd0) begin n_fail++; $display("FAIL clean_cnt: got %0d expected 0", vcnt); end
    endtask

    task automatic test_read_violation();
        logic [31:0] rd;
        logic        v;
        read_txn(32'h200, 4'h3, 4'b1101, 32'hAABBCCDD, 1'b0, rd, v);
        n_checks++; if (rd !== (CHK ? 32'hAABB00DD : 32'hAABBCCDD)) begin n_fail++; $display("FAIL viol_rdata: got %h expected %h", rd, CHK ? 32'hAABB00DD : 32'hAABBCCDD); end
        n_checks++; if (v !== CHK) begin n_fail++; $display("FAIL viol_pulse: got %b expected %b", v, CHK); end
        n_checks++; if (sticky !== CHK) begin n_fail++; $display("FAIL viol_sticky: got %b expected %b", sticky, CHK); end
        n_checks++; if (vaddr !== (CHK ? 32'h200 : 32'h0)) begin n_fail++; $display("FAIL viol_addr: got %h expected %h", vaddr, CHK ? 32'h200 : 32'h0); end
        n_checks++; if (vcnt !== (CHK ? 3'd1 : 3'd0)) begin n_fail++; $display("FAIL viol_cnt: got %0d expected %0d", vcnt, CHK ? 1 : 0); end
        n_checks++; if (viol !== 1'b0) begin n_fail++; $display("FAIL viol_pulse_end: got %b expected 0", viol); end
    endtask

    task automatic test_be_gate();
        logic [31:0] rd;
        logic        v;
        // Bad tags on bytes 3..2, which are not enabled.
        read_txn(32'h240, 4'h3, 4'b0011, 32'h99887766, 1'b0, rd, v);
        n_checks++; if (rd !== 32'h99887766) begin n_fail++; $display("FAIL be_gate_rdata: got %h expected 99887766", rd); end
        n_checks++; if (v !== 1'b0) begin n_fail++; $display("FAIL be_gate_viol: got %b expected 0", v); end
        n_checks++; if (vcnt !== (CHK ? 3'd1 : 3'd0)) begin n_fail++; $display("FAIL be_gate_cnt: got %0d expected %0d", vcnt, CHK ? 1 : 0); end
    endtask

    task automatic test_back_to_back();
        clr = 1'b1;
        next_cycle();
        clr = 1'b0;
        #1;
        n_checks++; if ({sticky, vaddr, vcnt} !== 36'h0) begin n_fail++; $display("FAIL clear_state: got %h expected 0", {sticky, vaddr, vcnt}); end
        s32.req = 1'b1; s32.wen = 1'b1; s32.add = 32'h300; s32.be = 4'hF; m36.gnt = 1'b1;
        next_cycle();
        s32.add = 32'h304;
        m36.r_valid = 1'b1; m36.r_rdata = {4'hF, 32'h11223344};
        #1;
        n_checks++; if (s32.r_rdata !== 32'h11223344) begin n_fail++; $display("FAIL b2b_first_rdata: got %h expected 11223344", s32.r_rdata); end
        n_checks++; if (viol !== 1'b0) begin n_fail++; $display("FAIL b2b_first_viol: got %b expected 0", viol); end
        next_cycle();
        s32.req = 1'b0; m36.gnt = 1'b0;
        m36.r_rdata = {4'b1110, 32'h55667788};
        #1;
        n_checks++; if (s32.r_rdata !== (CHK ? 32'h55667700 : 32'h55667788)) begin n_fail++; $display("FAIL b2b_second_rdata: got %h expected %h", s32.r_rdata, CHK ? 32'h55667700 : 32'h55667788); end
        n_checks++; if (viol !== CHK) begin n_fail++; $display("FAIL b2b_second_viol: got %b expected %b", viol, CHK); end
        next_cycle();
        idle_bus();
        #1;
        n_checks++; if (sticky !== CHK) begin n_fail++; $display("FAIL b2b_sticky: got %b expected %b", sticky, CHK); end
        n_checks++; if (vaddr !== (CHK ? 32'h304 : 32'h0)) begin n_fail++; $display("FAIL b2b_addr: got %h expected %h", vaddr, CHK ? 32'h304 : 32'h0); end
        n_checks++; if (vcnt !== (CHK ? 3'd1 : 3'd0)) begin n_fail++; $display("FAIL b2b_cnt: got %0d expected %0d", vcnt, CHK ? 1 : 0); end
    endtask

    task automatic test_saturate_and_clear();
        logic [31:0] rd;
        logic        v;
        // Six more violations take the 3-bit counter from 1 to 7.
        for (int i = 0; i < 6; i++) begin
            read_txn(32'h400 + 32'(4 * i), 4'h1, 4'b1110, 32'h0000_00A5, 1'b0, rd, v);
        end
        n_checks++; if (vcnt !== (CHK ? 3'd7 : 3'd0)) begin n_fail++; $display("FAIL sat_reach: got %0d expected %0d", vcnt, CHK ? 7 : 0); end
        read_txn(32'h480, 4'h1, 4'b1110, 32'h0000_00A5, 1'b0, rd, v);
        n_checks++; if (v !== CHK) begin n_fail++; $display("FAIL sat_pulse: got %b expected %b", v, CHK); end
        n_checks++; if (vcnt !== (CHK ? 3'd7 : 3'd0)) begin n_fail++; $display("FAIL sat_hold: got %0d expected %0d", vcnt, CHK ? 7 : 0); end
        n_checks++; if (vaddr !== (CHK ? 32'h304 : 32'h0)) begin n_fail++; $display("FAIL sat_addr_kept: got %h expected %h", vaddr, CHK ? 32'h304 : 32'h0); end
        // Clear coinciding with a violation: clear first, then record.
        read_txn(32'h500, 4'h8, 4'b0111, 32'h7700_0000, 1'b1, rd, v);
        n_checks++; if (rd !== (CHK ? 32'h0 : 32'h77000000)) begin n_fail++; $display("FAIL clrviol_rdata: got %h expected %h", rd, CHK ? 32'h0 : 32'h77000000); end
        n_checks++; if (sticky !== CHK) begin n_fail++; $display("FAIL clrviol_sticky: got %b expected %b", sticky, CHK); end
        n_checks++; if (vaddr !== (CHK ? 32'h500 : 32'h0)) begin n_fail++; $display("FAIL clrviol_addr: got %h expected %h", vaddr, CHK ? 32'h500 : 32'h0); end
        n_checks++; if (vcnt !== (CHK ? 3'd1 : 3'd0)) begin n_fail++; $display("FAIL clrviol_cnt: got %0d expected %0d", vcnt, CHK ? 1 : 0); end
    endtask

    task automatic test_reset_mid();
        // Reset sampled at the edge that grants the read.
        s32.req = 1'b1; s32.wen = 1'b1; s32.add = 32'h600; s32.be = 4'hF;
        m36.gnt = 1'b1; rst = 1'b1;
        next_cycle();
        rst = 1'b0; s32.req = 1'b0; m36.gnt = 1'b0;
        m36.r_valid = 1'b1; m36.r_rdata = {4'b0000, 32'hCAFEF00D};
        #1;
        n_checks++; if (s32.r_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rst_mid_rdata: got %h expected CAFEF00D", s32.r_rdata); end
        n_checks++; if (viol !== 1'b0) begin n_fail++; $display("FAIL rst_mid_viol: got %b expected 0", viol); end
        next_cycle();
        idle_bus();
        #1;
        n_checks++; if (sticky !== 1'b0) begin n_fail++; $display("FAIL rst_mid_sticky: got %b expected 0", sticky); end
        n_checks++; if (vaddr !== 32'h0) begin n_fail++; $display("FAIL rst_mid_addr: got %h expected 0", vaddr); end
        n_checks++; if (vcnt !== 3'd0) begin n_fail++; $display("FAIL rst_mid_cnt: got %0d expected 0", vcnt); end
    endtask

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        idle_bus();
        next_cycle();
        next_cycle();
        rst = 1'b0;
        #1;
        test_reset();
        test_write();
        test_read_clean();
        test_read_violation();
        test_be_gate();
        test_back_to_back();
        test_saturate_and_clear();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
